// File: rtl/alu_cmd_ctrl.sv
// ============================================================================
// alu_cmd_ctrl: byte-stream command sequencer between UART RX/TX and the ALU.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_ctrl #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    WAIT_MAX     = 15,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_OPER = 8'hCC,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP  = 8'hDD
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
  input  logic                      RX_D_VLD,
  output logic [DATA_WIDTH-1:0]     ALU_A,
  output logic [DATA_WIDTH-1:0]     ALU_B,
  output logic [3:0]                ALU_FUN,
  output logic                      ALU_EN,
  input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
  input  logic                      ALU_OUT_VLD,
  output logic [DATA_WIDTH-1:0]     TX_P_DATA,
  output logic                      TX_D_VLD,
  input  logic                      TX_BUSY,
  output logic                      CMD_ERR,
  output logic                      BUSY
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_A    = 3'd1,
    S_GET_B    = 3'd2,
    S_GET_FUN  = 3'd3,
    S_ALU_RUN  = 3'd4,
    S_ALU_WAIT = 3'd5,
    S_TX_LSB   = 3'd6,
    S_TX_MSB   = 3'd7
  } state_t;

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  // The ALU_EN cycle counts as the first waited cycle, so the last
  // ALU_WAIT cycle is reached with the counter at WAIT_MAX-2.
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WAIT_MAX - 2);

  state_t                  state_q,  state_d;
  logic [DATA_WIDTH-1:0]   alu_a_q,  alu_a_d;
  logic [DATA_WIDTH-1:0]   alu_b_q,  alu_b_d;
  logic [3:0]              alu_fun_q, alu_fun_d;
  logic [2*DATA_WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0]        cnt_q,    cnt_d;
  logic                    err_q,    err_d;
  logic                    w_busy;

  assign w_busy = (state_q == S_ALU_RUN) || (state_q == S_ALU_WAIT) ||
                  (state_q == S_TX_LSB)  || (state_q == S_TX_MSB);

  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_fun_d = alu_fun_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;

    // Bytes arriving while busy are dropped and flagged.
    if (RX_D_VLD && w_busy) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_ALU_OPER) begin
            state_d = S_GET_A;
          end else if (RX_P_DATA == CMD_ALU_NOP) begin
            state_d = S_GET_FUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_GET_A: begin
        if (RX_D_VLD) begin
          alu_a_d = RX_P_DATA;
          state_d = S_GET_B;
        end
      end
      S_GET_B: begin
        if (RX_D_VLD) begin
          alu_b_d = RX_P_DATA;
          state_d = S_GET_FUN;
        end
      end
      S_GET_FUN: begin
        if (RX_D_VLD) begin
          alu_fun_d = RX_P_DATA[3:0];
          state_d   = S_ALU_RUN;
        end
      end
      S_ALU_RUN: begin
        cnt_d   = '0;
        state_d = S_ALU_WAIT;
      end
      S_ALU_WAIT: begin
        if (ALU_OUT_VLD) begin
          result_d = ALU_OUT;
          state_d  = S_TX_LSB;
        end else if (cnt_q == C_CNT_LAST) begin
          result_d = '1;
          err_d    = 1'b1;
          state_d  = S_TX_LSB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TX_LSB: begin
        if (!TX_BUSY) begin
          state_d = S_TX_MSB;
        end
      end
      S_TX_MSB: begin
        if (!TX_BUSY) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_fun_q <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_fun_q <= alu_fun_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_FUN   = alu_fun_q;
  assign ALU_EN    = (state_q == S_ALU_RUN);
  assign TX_D_VLD  = (state_q == S_TX_LSB) || (state_q == S_TX_MSB);
  assign TX_P_DATA = (state_q == S_TX_MSB) ? result_q[2*DATA_WIDTH-1:DATA_WIDTH]
                                           : result_q[DATA_WIDTH-1:0];
  assign CMD_ERR   = err_q;
  assign BUSY      = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_ctrl.sv
// ============================================================================
// tb_alu_cmd_ctrl: scoreboard bench for alu_cmd_ctrl with a registered ALU model.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_cmd_ctrl;

  logic        CLK;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [7:0]  ALU_A;
  logic [7:0]  ALU_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_BUSY;
  logic        CMD_ERR;
  logic        BUSY;

  int          checks = 0;
  int          fails  = 0;
  logic [7:0]  exp_q[$];
  logic        alu_dead;

  alu_cmd_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_P_DATA   (RX_P_DATA),
    .RX_D_VLD    (RX_D_VLD),
    .ALU_A       (ALU_A),
    .ALU_B       (ALU_B),
    .ALU_FUN     (ALU_FUN),
    .ALU_EN      (ALU_EN),
    .ALU_OUT     (ALU_OUT),
    .ALU_OUT_VLD (ALU_OUT_VLD),
    .TX_P_DATA   (TX_P_DATA),
    .TX_D_VLD    (TX_D_VLD),
    .TX_BUSY     (TX_BUSY),
    .CMD_ERR     (CMD_ERR),
    .BUSY        (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Registered ALU: result and valid one cycle after ALU_EN.
  always @(posedge CLK) begin
    if (!RST) begin
      ALU_OUT_VLD <= 1'b0;
      ALU_OUT     <= 16'h0000;
    end else begin
      ALU_OUT_VLD <= ALU_EN && !alu_dead;
      if (ALU_EN) begin
        case (ALU_FUN)
          4'd0:    ALU_OUT <= {8'h00, ALU_A} + {8'h00, ALU_B};
          4'd1:    ALU_OUT <= {8'h00, ALU_A} - {8'h00, ALU_B};
          4'd2:    ALU_OUT <= {8'h00, ALU_A} * {8'h00, ALU_B};
          default: ALU_OUT <= 16'h0000;
        endcase
      end
    end
  end

  // Monitor: every accepted TX byte is popped and compared.
  always @(negedge CLK) begin
    logic [7:0] e;
    if (RST && TX_D_VLD && !TX_BUSY) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL tx_byte: got %02h, expected no byte", TX_P_DATA);
      end else begin
        e = exp_q.pop_front();
        if (TX_P_DATA !== e) begin
          fails++;
          $display("FAIL tx_byte: got %02h, expected %02h", TX_P_DATA, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY && n < 100) begin
      tick();
      n++;
    end
    chk("idle_reached", {15'd0, BUSY}, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic early;
    RST       = 1'b0;
    RX_P_DATA = 8'h00;
    RX_D_VLD  = 1'b0;
    TX_BUSY   = 1'b0;
    alu_dead  = 1'b0;
    tick();
    tick();
    chk("rst_alu_a",   {8'h00, ALU_A}, 16'h0);
    chk("rst_alu_fun", {12'h0, ALU_FUN}, 16'h0);
    chk("rst_outputs", {11'h0, ALU_EN, TX_D_VLD, CMD_ERR, BUSY, 1'b0}, 16'h0);
    chk("rst_tx_data", {8'h00, TX_P_DATA}, 16'h0);
    RST = 1'b1;
    tick();

    // 1: multiply 0F*03 = 002D, latency check
    send_byte(8'hCC); send_byte(8'h0F); send_byte(8'h03);
    exp_q.push_back(8'h2D); exp_q.push_back(8'h00);
    send_byte(8'h02);
    chk("t1_alu_en_t1", {15'd0, ALU_EN}, 16'd1);
    chk("t1_alu_fun", {12'h0, ALU_FUN}, 16'h2);
    tick();
    chk("t1_alu_en_t2", {15'd0, ALU_EN}, 16'd0);
    chk("t1_txvld_t2", {15'd0, TX_D_VLD}, 16'd0);
    tick();
    chk("t1_txvld_t3", {15'd0, TX_D_VLD}, 16'd1);
    wait_idle();
    chk("t1_txvld_after", {15'd0, TX_D_VLD}, 16'd0);

    // 2: NOP frame reuses stored operands, add -> 0012
    send_byte(8'hDD);
    exp_q.push_back(8'h12); exp_q.push_back(8'h00);
    send_byte(8'hF0);
    chk("t2_alu_a", {8'h00, ALU_A}, 16'h0F);
    chk("t2_alu_b", {8'h00, ALU_B}, 16'h03);
    chk("t2_fun_low_nibble", {12'h0, ALU_FUN}, 16'h0);
    wait_idle();

    // 3: TX_BUSY held for 5 cycles during TX_LSB
    send_byte(8'hCC); send_byte(8'h0F); send_byte(8'h03);
    exp_q.push_back(8'h2D); exp_q.push_back(8'h00);
    send_byte(8'h02);
    TX_BUSY = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_vld", {15'd0, TX_D_VLD}, 16'd1);
      chk("t3_hold_data", {8'h00, TX_P_DATA}, 16'h2D);
      tick();
    end
    chk("t3_queue_pending", 16'(exp_q.size()), 16'd2);
    TX_BUSY = 1'b0;
    wait_idle();

    // 4a: illegal command byte in IDLE
    send_byte(8'h55);
    chk("t4_err_idle", {15'd0, CMD_ERR}, 16'd1);
    chk("t4_busy_idle", {15'd0, BUSY}, 16'd0);
    tick();
    chk("t4_err_pulse", {15'd0, CMD_ERR}, 16'd0);

    // 4b: stray byte during ALU_WAIT is dropped
    send_byte(8'hCC); send_byte(8'h0F); send_byte(8'h03);
    exp_q.push_back(8'h2D); exp_q.push_back(8'h00);
    send_byte(8'h02);
    tick();
    send_byte(8'h11);
    chk("t4_err_wait", {15'd0, CMD_ERR}, 16'd1);
    chk("t4_alu_a_held", {8'h00, ALU_A}, 16'h0F);
    tick();
    chk("t4_err_wait_pulse", {15'd0, CMD_ERR}, 16'd0);
    wait_idle();

    // 5: ALU never responds -> timeout error and FF FF
    alu_dead = 1'b1;
    send_byte(8'hCC); send_byte(8'h01); send_byte(8'h02);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    send_byte(8'h00);
    chk("t5_alu_en", {15'd0, ALU_EN}, 16'd1);
    early = 1'b0;
    for (int i = 1; i < 15; i++) begin
      tick();
      if (CMD_ERR || TX_D_VLD) early = 1'b1;
    end
    chk("t5_no_early_err", {15'd0, early}, 16'd0);
    tick();
    chk("t5_timeout_err", {15'd0, CMD_ERR}, 16'd1);
    chk("t5_timeout_txvld", {15'd0, TX_D_VLD}, 16'd1);
    tick();
    chk("t5_err_pulse", {15'd0, CMD_ERR}, 16'd0);
    wait_idle();
    alu_dead = 1'b0;

    // 6: reset mid-frame clears operands
    send_byte(8'hCC);
    send_byte(8'h0A);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    chk("t6_rst_alu_a", {8'h00, ALU_A}, 16'h0);
    chk("t6_rst_alu_b", {8'h00, ALU_B}, 16'h0);
    chk("t6_rst_outputs", {11'h0, ALU_EN, TX_D_VLD, CMD_ERR, BUSY, 1'b0}, 16'h0);
    send_byte(8'hDD);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    send_byte(8'h00);
    chk("t6_alu_a_zero", {8'h00, ALU_A}, 16'h0);
    chk("t6_alu_b_zero", {8'h00, ALU_B}, 16'h0);
    wait_idle();

    tick();
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
